// File: rtl/dlfloat_pkg.sv
// Shared types for the DLFloat16 MAC sequencer: operand format, FSM states, zero constant.
package dlfloat_pkg;

  typedef struct packed {
    logic       sign;
    logic [5:0] exp;
    logic [8:0] mant;
  } dlfloat16_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } mac_state_t;

  localparam logic [15:0] DLF_ZERO = 16'h0000;

  function automatic logic dlf_is_zero(input dlfloat16_t v);
    return 16'(v) == DLF_ZERO;
  endfunction

endpackage

// File: rtl/dlfloat_lat_tracker.sv
// Shift register of in-flight datapath tokens (mac_en / mac_clr); o_empty is high
// once every token has aged through the MAC latency and none is entering.
module dlfloat_lat_tracker #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tok,
  output logic o_empty
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sr <= '0;
        else        r_sr <= i_tok;
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sr <= '0;
        else        r_sr <= {r_sr[DEPTH-2:0], i_tok};
      end
    end
  endgenerate

  assign o_empty = ~i_tok & ~(|r_sr);

endmodule

// File: rtl/dlfloat_mac_seq.sv
// Dot-product sequencer feeding a DLFloat16 MAC datapath.
// Optional macro DLFLOAT_MAC_SEQ_ZERO_SKIP_EN: pairs with a zero operand are counted but not issued.
//
// state    | meaning
// ST_IDLE  | waiting for start; len latched and mac_clr launched on start
// ST_LOAD  | accepting operand pairs, one mac_en per issued pair
// ST_DRAIN | waiting for outstanding datapath tokens to retire, then capture acc_in
// ST_OUT   | holding result until out_ready
module dlfloat_mac_seq
  import dlfloat_pkg::*;
#(
  parameter int unsigned MAC_LAT = 3,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [15:0]      acc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
);

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  mac_state_t       r_state, w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W:0]   r_cnt;
  logic [LEN_W:0]   w_cnt_nx;
  dlfloat16_t       r_mac_a, r_mac_b;
  logic             r_mac_en, r_mac_clr;
  logic [15:0]      r_out_data;
  logic             w_start, w_hs, w_last, w_issue, w_empty;

  assign w_start  = (r_state == ST_IDLE) && start;
  assign w_hs     = (r_state == ST_LOAD) && in_valid;
  assign w_cnt_nx = r_cnt + CNT_ONE;
  assign w_last   = w_hs && (w_cnt_nx == {1'b0, r_len});

`ifdef DLFLOAT_MAC_SEQ_ZERO_SKIP_EN
  assign w_issue = w_hs && !dlf_is_zero(in_a) && !dlf_is_zero(in_b);
`else
  assign w_issue = w_hs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = (len == '0) ? ST_DRAIN : ST_LOAD;
      ST_LOAD:  if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: if (w_empty) w_next = ST_OUT;
      ST_OUT:   if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_mac_a    <= '0;
      r_mac_b    <= '0;
      r_mac_en   <= 1'b0;
      r_mac_clr  <= 1'b0;
      r_out_data <= DLF_ZERO;
    end else begin
      r_mac_clr <= w_start;
      r_mac_en  <= w_issue;
      if (w_start) begin
        r_len <= len;
        r_cnt <= '0;
      end
      if (w_hs) begin
        r_mac_a <= dlfloat16_t'(in_a);
        r_mac_b <= dlfloat16_t'(in_b);
        r_cnt   <= w_cnt_nx;
      end
      if ((r_state == ST_DRAIN) && w_empty) r_out_data <= acc_in;
    end
  end

  // The clear token counts as in-flight so an empty job still waits out the latency.
  dlfloat_lat_tracker #(.DEPTH(MAC_LAT)) u_lat (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_tok   (r_mac_en | r_mac_clr),
    .o_empty (w_empty)
  );

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_OUT);
  assign busy      = (r_state != ST_IDLE);
  assign mac_a     = 16'(r_mac_a);
  assign mac_b     = 16'(r_mac_b);
  assign mac_en    = r_mac_en;
  assign mac_clr   = r_mac_clr;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Directed bench for dlfloat_mac_seq with a behavioural accumulator and a result scoreboard.
module tb_dlfloat_mac_seq;

  localparam int L  = 3;
  localparam int LW = 8;
`ifdef DLFLOAT_MAC_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_a = '0, in_b = '0;
  logic [15:0]   mac_a, mac_b;
  logic          mac_en, mac_clr;
  logic [15:0]   acc_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_data;
  logic          busy;

  dlfloat_mac_seq #(.MAC_LAT(L), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  int          cyc = 0, n_en = 0, n_clr = 0, n_hs = 0, n_out = 0, last_tok = 0;
  logic        ov_prev = 1'b0;
  logic [15:0] od_hold = '0;
  logic [15:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: records the pending handshake, then samples #1 after the edge.
  task automatic step();
    logic        hs, exp_en;
    logic [15:0] ha, hb;
    hs = in_valid && in_ready && rst_n;
    ha = in_a;
    hb = in_b;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) n_hs++;
    exp_en = hs && !(ZS && (ha == 16'h0 || hb == 16'h0));
    check("mac_en_timing", 32'(mac_en), 32'(exp_en));
    check("clr_en_overlap", 32'(mac_en & mac_clr), 32'd0);
    if (hs) begin
      check("mac_a", 32'(mac_a), 32'(ha));
      check("mac_b", 32'(mac_b), 32'(hb));
    end
    if (mac_clr) begin
      n_clr++;
      last_tok = cyc;
      acc_in = 16'h0;
    end
    if (mac_en) begin
      n_en++;
      last_tok = cyc;
      acc_in = acc_in + mac_a + mac_b;
    end
    if (out_valid && !ov_prev) begin
      n_out++;
      check("out_latency", 32'(cyc - last_tok), 32'(L + 2));
      check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) check("out_data", 32'(out_data), 32'(sb_q.pop_front()));
    end else if (out_valid) begin
      check("out_hold", 32'(out_data), 32'(od_hold));
    end
    ov_prev = out_valid;
    od_hold = out_data;
  endtask

  task automatic start_job(input int n, input logic [15:0] expv);
    start = 1'b1;
    len = LW'(n);
    sb_q.push_back(expv);
    step();
    start = 1'b0;
    check("clr_pulse", 32'(mac_clr), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic feed(input logic [15:0] a, input logic [15:0] b);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    check("feed_timeout", 32'(g < 50), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!out_valid && g < 100) begin
      step();
      g++;
    end
    check("out_timeout", 32'(g < 100), 32'd1);
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_drop", 32'(out_valid), 32'd0);
    check("busy_off", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] pa[4], pb[4], e;
    int c0, h0, en0, clr0;

    // reset state
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_mac_clr", 32'(mac_clr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mac_a", 32'(mac_a), 32'd0);
    check("rst_mac_b", 32'(mac_b), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // len=3, back-to-back pairs
    pa = '{16'h3C00, 16'h3C00, 16'h0000, 16'h0000};
    pb = '{16'h3C00, 16'h4000, 16'h0000, 16'h0000};
    e = '0;
    for (int i = 0; i < 3; i++) e = e + pa[i] + pb[i];
    en0 = n_en; h0 = n_hs; clr0 = n_clr;
    start_job(3, e);
    c0 = cyc;
    for (int i = 0; i < 3; i++) feed(pa[i], pb[i]);
    check("len3_consecutive", 32'(cyc - c0), 32'd3);
    check("len3_hs", 32'(n_hs - h0), 32'd3);
    check("len3_ready_low", 32'(in_ready), 32'd0);
    wait_valid();
    finish_out();
    check("len3_mac_en", 32'(n_en - en0), ZS ? 32'd2 : 32'd3);
    check("len3_mac_clr", 32'(n_clr - clr0), 32'd1);

    // len=0: only the clear, result is the cleared accumulator
    en0 = n_en;
    start_job(0, 16'h0000);
    check("len0_no_ready", 32'(in_ready), 32'd0);
    wait_valid();
    finish_out();
    check("len0_mac_en", 32'(n_en - en0), 32'd0);

    // len=4 with in_valid toggling
    pa = '{16'h1111, 16'h0333, 16'h1000, 16'h7FFF};
    pb = '{16'h2222, 16'h0444, 16'h0001, 16'h0001};
    e = '0;
    for (int i = 0; i < 4; i++) e = e + pa[i] + pb[i];
    en0 = n_en; h0 = n_hs;
    start_job(4, e);
    for (int i = 0; i < 4; i++) begin
      feed(pa[i], pb[i]);
      step();
    end
    in_valid = 1'b1;
    in_a = 16'h5555;
    in_b = 16'h5555;
    step();
    check("len4_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    step();
    step();
    check("len4_hs", 32'(n_hs - h0), 32'd4);
    check("len4_mac_en", 32'(n_en - en0), 32'd4);
    wait_valid();
    finish_out();

    // result held under back-pressure; start ignored outside IDLE
    start_job(1, 16'h3000);
    feed(16'h2000, 16'h1000);
    wait_valid();
    clr0 = n_clr;
    for (int i = 0; i < 10; i++) begin
      start = (i % 2) == 0;
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    check("ack_start_out", 32'(out_valid), 32'd0);
    check("ack_start_busy", 32'(busy), 32'd0);
    step();
    check("ack_start_noclr", 32'(n_clr - clr0), 32'd0);
    check("ack_start_idle", 32'(busy), 32'd0);

    // async reset mid-LOAD, then a fresh len=1 job
    start_job(5, 16'hDEAD);
    feed(16'h0101, 16'h0101);
    feed(16'h0202, 16'h0202);
    in_valid = 1'b1;
    in_a = 16'h0303;
    in_b = 16'h0303;
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_mac_en", 32'(mac_en), 32'd0);
    check("arst_mac_clr", 32'(mac_clr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_mac_a", 32'(mac_a), 32'd0);
    check("arst_mac_b", 32'(mac_b), 32'd0);
    sb_q.delete();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    start_job(1, 16'h0800);
    feed(16'h0400, 16'h0400);
    wait_valid();
    finish_out();

    // len=255 continuous
    e = '0;
    for (int i = 0; i < 255; i++) e = e + 16'(i + 1) + 16'h0001;
    h0 = n_hs;
    start_job(255, e);
    c0 = cyc;
    for (int i = 0; i < 255; i++) feed(16'(i + 1), 16'h0001);
    check("len255_consecutive", 32'(cyc - c0), 32'd255);
    check("len255_hs", 32'(n_hs - h0), 32'd255);
    check("len255_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("len255_no_extra", 32'(n_hs - h0), 32'd255);
    wait_valid();
    finish_out();

    check("jobs_out", 32'(n_out), 32'd6);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dlfloat_mac_seq.md
DLFLOAT_MAC_SEQ -- requirements
Module: dlfloat_mac_seq

Interface
REQ-001 SHALL have parameter MAC_LAT, default 3: cycles from mac_en to the updated accumulator on acc_in (legal range 1..15).
REQ-002 SHALL have parameter LEN_W, default 8: width of the term-count input.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 start  input  1  request a new dot product; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of operand pairs; sampled with start.
REQ-008 in_valid/in_ready  input/output  1/1  operand-pair handshake.
REQ-009 in_a, in_b  input  16/16  DLFloat16 operands (sign, 6-bit exponent, 9-bit mantissa).
REQ-010 mac_a, mac_b  output  16/16  registered operands to the MAC datapath.
REQ-011 mac_en  output  1  one-cycle strobe: datapath consumes mac_a/mac_b.
REQ-012 mac_clr  output  1  one-cycle accumulator clear.
REQ-013 acc_in  input  16  accumulator value from the datapath.
REQ-014 out_valid/out_ready  output/input  1/1  result handshake.
REQ-015 out_data  output  16  final accumulated DLFloat16 result.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> DRAIN -> OUT -> IDLE.
REQ-018 IDLE: start=1 latches len, clears the issue counter, and pulses mac_clr for exactly the next cycle.
- Goes to LOAD if len!=0.
- Goes to DRAIN if len==0.
REQ-019 LOAD: in_ready=1.
- Each in_valid&in_ready registers in_a/in_b onto mac_a/mac_b and asserts mac_en on the following cycle.
- The issue counter increments per handshake.
REQ-020 LOAD -> DRAIN on the handshake that makes the issue count equal len; in_ready SHALL be 0 from the next cycle.
REQ-021 in_ready SHALL be 0 in IDLE, DRAIN and OUT.
REQ-022 DRAIN: wait until MAC_LAT cycles have elapsed after the last mac_en, then capture acc_in into out_data and enter OUT.
- With no mac_en issued, wait MAC_LAT cycles after mac_clr, then capture.
REQ-023 OUT: out_valid=1 and out_data stable until out_ready=1; that cycle returns the FSM to IDLE and deasserts out_valid.
REQ-024 start outside IDLE SHALL be ignored; out_valid&out_ready and start in the same cycle SHALL NOT start a new job until the next IDLE cycle.
REQ-025 Issue counter is LEN_W+1 bits wide and SHALL never wrap; len = 2^LEN_W-1 is fully supported.
REQ-026 mac_en SHALL never assert outside the cycle following a LOAD handshake; mac_clr SHALL never coincide with mac_en.

Reset
REQ-027 While rst_n is low, regardless of state, the block SHALL asynchronously force:
- state to IDLE;
- in_ready, mac_en, mac_clr, out_valid and busy to 0;
- mac_a, mac_b, out_data and counters to 16'h0000 / 0.
REQ-028 Reset mid-job SHALL abandon the job silently; no out_valid is produced for it.

Configuration
REQ-029 Macro DLFLOAT_MAC_SEQ_ZERO_SKIP_EN:
- Defined: a handshaked pair where in_a==16'h0000 or in_b==16'h0000 is consumed and counted, but mac_en is not asserted.
- Undefined: every handshaked pair asserts mac_en.

Structure
REQ-030 Package dlfloat_pkg SHALL hold the dlfloat16_t packed typedef (sign/exp/mant fields), the FSM state enum, and constant DLF_ZERO = 16'h0000.
REQ-031 Sub-module dlfloat_lat_tracker SHALL be a MAC_LAT-deep shift register of mac_en/mac_clr tokens whose empty output gates the DRAIN exit.

Verification
REQ-032 len=3, pairs (3C00,3C00),(3C00,4000),(0,0), in_valid always high -> mac_clr once, then three handshakes in consecutive cycles.
- mac_en count: 3, or 2 with ZERO_SKIP_EN.
- out_valid exactly MAC_LAT cycles after the last LOAD-issued strobe completes.
- out_data equals the acc_in value at capture.
REQ-033 len=0 -> no mac_en; out_valid after MAC_LAT+2 cycles; out_data = acc_in at capture (datapath cleared, 16'h0000).
REQ-034 len=4 with in_valid toggling 1,0,1,0... -> exactly 4 mac_en, each one cycle after its handshake; no extra handshake after the 4th.
REQ-035 out_ready held low 10 cycles in OUT -> out_valid and out_data stable for all 10; start pulses during this period are ignored.
REQ-036 rst_n dropped asynchronously mid-LOAD (2 of 5 pairs issued) -> all outputs 0 immediately; after release, a new len=1 job completes normally.
REQ-037 len=255, continuous in_valid -> 255 handshakes, in_ready low from the cycle after the 255th, counter does not wrap.
